// File: rtl/iic_write_phy.sv
// iic_write_phy
//   Bit-level I2C/SCCB write engine. Each accepted request sends one frame:
//   slave address (R/W forced to 0), register address (8 or 16 bits, high
//   byte first) and one data byte, followed by STOP and a bus-free gap.
//
// Parameters
//   CLK_FRE           system clock in MHz
//   IIC_FRE           SCL frequency in kHz
//   IIC_SLAVE_REG_EX  0: 8-bit register address, 1: 16-bit register address
//   IIC_SLAVE_ADDR    8-bit write address, bit 0 is forced to 0 on the bus
//
// Ports
//   clk        system clock, single domain
//   rst_n      active-low reset, synchronous to clk
//   send_en    write request, level-sampled only while idle
//   reg_addr   register address (8 + 8*IIC_SLAVE_REG_EX bits)
//   send_data  data byte
//   send_busy  high from the cycle after acceptance until the bus-free gap ends
//   nack       at least one ACK slot of the last transaction read high
//   iic_scl    SCL, push-pull
//   iic_sda    SDA, open-drain (driven 0 or released)
//
// Build option
//   IIC_ACK_CHECK_EN  when defined, ACK slots are sampled; a high sample sets
//                     nack and aborts straight to STOP. When undefined, ACK
//                     slots are released but ignored and nack is tied to 0.

module iic_write_phy #(
  parameter int         CLK_FRE          = 50,
  parameter int         IIC_FRE          = 100,
  parameter int         IIC_SLAVE_REG_EX = 1,
  parameter logic [7:0] IIC_SLAVE_ADDR   = 8'h78
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            send_en,
  input  logic [8+8*IIC_SLAVE_REG_EX-1:0] reg_addr,
  input  logic [7:0]                      send_data,
  output logic                            send_busy,
  output logic                            nack,
  output logic                            iic_scl,
  inout  wire                             iic_sda
);

  // state   | meaning
  // --------+-------------------------------------------------------------
  // S_IDLE  | bus idle, waiting for send_en
  // S_START | 2 quarters: SCL=1/SDA=1, then SCL=1/SDA=0
  // S_BIT   | 4 quarters per bit, SDA set in Q0, SCL high in Q2..Q3
  // S_ACK   | 4 quarters, SDA released, sampled on the last clock of Q3
  // S_STOP  | 3 quarters: SCL=0/SDA=0, SCL=1/SDA=0, SCL=1/SDA=1
  // S_FREE  | 4 quarters of bus-free time before returning to idle

  localparam int DIV        = (CLK_FRE * 1000) / (IIC_FRE * 4);
  localparam int N_BYTES    = 3 + IIC_SLAVE_REG_EX;
  localparam int FRAME_W    = 8 * N_BYTES;
  localparam int CNT_W      = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);
  localparam logic [1:0]       BYTES_LAST = 2'(N_BYTES - 1);

  if (DIV < 2) begin : g_div_check
    $error("iic_write_phy: quarter divider must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_ACK,
    S_STOP,
    S_FREE
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           quarter_q, quarter_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [1:0]           bytes_left_q, bytes_left_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 scl_q, scl_d;
  logic                 sda_low_q, sda_low_d;
  logic                 busy_q;
  logic                 tick;
  logic                 ack_fail;

  // Quarter tick from a down-counter; the counter is reloaded on acceptance
  // so the first quarter of every frame is a full DIV clocks long.
  assign tick = (cnt_q == '0) && (state_q != S_IDLE);

`ifdef IIC_ACK_CHECK_EN
  logic nack_q;

  assign ack_fail = iic_sda;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nack_q <= 1'b0;
    end else if ((state_q == S_IDLE) && send_en) begin
      nack_q <= 1'b0;
    end else if ((state_q == S_ACK) && tick && (quarter_q == 2'd3) && iic_sda) begin
      nack_q <= 1'b1;
    end
  end

  assign nack = nack_q;
`else
  assign ack_fail = 1'b0;
  assign nack     = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    quarter_d    = quarter_q;
    bit_cnt_d    = bit_cnt_q;
    bytes_left_d = bytes_left_q;
    frame_d      = frame_q;
    cnt_d        = cnt_q;
    scl_d        = 1'b1;
    sda_low_d    = 1'b0;

    if (state_q != S_IDLE) begin
      cnt_d = (cnt_q == '0) ? DIV_LAST : cnt_q - CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (send_en) begin
          state_d      = S_START;
          quarter_d    = 2'd0;
          cnt_d        = DIV_LAST;
          frame_d      = {IIC_SLAVE_ADDR & 8'hFE, reg_addr, send_data};
          bytes_left_d = BYTES_LAST;
          bit_cnt_d    = 3'd7;
        end
      end

      S_START: begin
        if (tick) begin
          if (quarter_q == 2'd1) begin
            state_d   = S_BIT;
            quarter_d = 2'd0;
            bit_cnt_d = 3'd7;
          end else begin
            quarter_d = quarter_q + 2'd1;
          end
        end
      end

      S_BIT: begin
        if (tick) begin
          quarter_d = quarter_q + 2'd1;
          if (quarter_q == 2'd3) begin
            // Shift at the end of the bit so the next MSB is ready for Q0.
            frame_d = frame_q << 1;
            if (bit_cnt_q == 3'd0) begin
              state_d = S_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end
        end
      end

      S_ACK: begin
        if (tick) begin
          quarter_d = quarter_q + 2'd1;
          if (quarter_q == 2'd3) begin
            if (ack_fail || (bytes_left_q == 2'd0)) begin
              state_d = S_STOP;
            end else begin
              state_d      = S_BIT;
              bytes_left_d = bytes_left_q - 2'd1;
              bit_cnt_d    = 3'd7;
            end
          end
        end
      end

      S_STOP: begin
        if (tick) begin
          if (quarter_q == 2'd2) begin
            state_d   = S_FREE;
            quarter_d = 2'd0;
          end else begin
            quarter_d = quarter_q + 2'd1;
          end
        end
      end

      S_FREE: begin
        if (tick) begin
          quarter_d = quarter_q + 2'd1;
          if (quarter_q == 2'd3) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Pins are decoded from the next state and registered, so they line up
    // with the state register and never glitch.
    case (state_d)
      S_START: begin
        sda_low_d = (quarter_d == 2'd1);
      end
      S_BIT: begin
        scl_d     = quarter_d[1];
        sda_low_d = ~frame_d[FRAME_W-1];
      end
      S_ACK: begin
        scl_d = quarter_d[1];
      end
      S_STOP: begin
        scl_d     = (quarter_d != 2'd0);
        sda_low_d = (quarter_d != 2'd2);
      end
      default: begin
        scl_d     = 1'b1;
        sda_low_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      quarter_q    <= 2'd0;
      bit_cnt_q    <= 3'd0;
      bytes_left_q <= 2'd0;
      frame_q      <= '0;
      cnt_q        <= '0;
      scl_q        <= 1'b1;
      sda_low_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      quarter_q    <= quarter_d;
      bit_cnt_q    <= bit_cnt_d;
      bytes_left_q <= bytes_left_d;
      frame_q      <= frame_d;
      cnt_q        <= cnt_d;
      scl_q        <= scl_d;
      sda_low_q    <= sda_low_d;
      busy_q       <= (state_d != S_IDLE);
    end
  end

  assign iic_scl   = scl_q;
  assign iic_sda   = sda_low_q ? 1'b0 : 1'bz;
  assign send_busy = busy_q;

endmodule

// File: tb/tb_iic_write_phy.sv
// Directed bench for iic_write_phy: two instances (16-bit and 8-bit register
// address) at CLK_FRE=4 / IIC_FRE=250, each with a pulled-up SDA and a small
// slave model that captures bytes on SCL rise and ACKs unless told otherwise.

module tb_iic_write_phy;

  localparam int NONE = -1;

`ifdef IIC_ACK_CHECK_EN
  localparam bit ACK_CHK = 1'b1;
`else
  localparam bit ACK_CHK = 1'b0;
`endif

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        en_a   = 1'b0;
  logic        en_b   = 1'b0;
  logic [15:0] reg_a  = '0;
  logic [7:0]  reg_b  = '0;
  logic [7:0]  data_a = '0;
  logic [7:0]  data_b = '0;
  logic        busy_a, busy_b, nack_a, nack_b, scl_a, scl_b;
  wire         sda_a, sda_b;

  logic        drv [2]     = '{1'b0, 1'b0};
  logic        scl_p [2]   = '{1'b1, 1'b1};
  logic        sda_p [2]   = '{1'b1, 1'b1};
  logic [7:0]  sh [2]      = '{8'h00, 8'h00};
  int          bitn [2]    = '{0, 0};
  int          fbyte [2]   = '{0, 0};
  int          rx_cnt [2]  = '{0, 0};
  int          starts [2]  = '{0, 0};
  int          stops [2]   = '{0, 0};
  int          nack_at [2];
  logic [7:0]  rx_byte [2][64];

  int n_checks = 0;
  int n_errors = 0;

  assign sda_a = drv[0] ? 1'b0 : 1'bz;
  assign sda_b = drv[1] ? 1'b0 : 1'bz;
  pullup (sda_a);
  pullup (sda_b);

  always #5 clk = ~clk;

  iic_write_phy #(
    .CLK_FRE(4), .IIC_FRE(250), .IIC_SLAVE_REG_EX(1), .IIC_SLAVE_ADDR(8'h78)
  ) u_dut_ex1 (
    .clk(clk), .rst_n(rst_n), .send_en(en_a), .reg_addr(reg_a),
    .send_data(data_a), .send_busy(busy_a), .nack(nack_a),
    .iic_scl(scl_a), .iic_sda(sda_a)
  );

  iic_write_phy #(
    .CLK_FRE(4), .IIC_FRE(250), .IIC_SLAVE_REG_EX(0), .IIC_SLAVE_ADDR(8'h78)
  ) u_dut_ex0 (
    .clk(clk), .rst_n(rst_n), .send_en(en_b), .reg_addr(reg_b),
    .send_data(data_b), .send_busy(busy_b), .nack(nack_b),
    .iic_scl(scl_b), .iic_sda(sda_b)
  );

  // Slave model, sampled mid-cycle so DUT outputs are stable.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic sc, sd;
      sc = (i == 0) ? scl_a : scl_b;
      sd = (i == 0) ? sda_a : sda_b;
      if (sc && scl_p[i] && (sd != sda_p[i])) begin
        if (!sd) begin
          starts[i] = starts[i] + 1;
          bitn[i]   = 0;
          fbyte[i]  = 0;
          drv[i]    = 1'b0;
        end else begin
          stops[i] = stops[i] + 1;
        end
      end else if (sc && !scl_p[i]) begin
        if (bitn[i] < 8) begin
          sh[i]   = {sh[i][6:0], sd};
          bitn[i] = bitn[i] + 1;
          if (bitn[i] == 8 && rx_cnt[i] < 64) begin
            rx_byte[i][rx_cnt[i]] = sh[i];
            rx_cnt[i] = rx_cnt[i] + 1;
          end
        end else begin
          bitn[i] = 9;
        end
      end else if (!sc && scl_p[i]) begin
        if (bitn[i] == 8) begin
          drv[i] = (fbyte[i] != nack_at[i]);
        end else if (bitn[i] == 9) begin
          drv[i]   = 1'b0;
          bitn[i]  = 0;
          fbyte[i] = fbyte[i] + 1;
        end
      end
      scl_p[i] = sc;
      sda_p[i] = sd;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic busy_of(input int idx);
    return (idx == 0) ? busy_a : busy_b;
  endfunction

  task automatic snap(input int idx, output int rx0, output int st0, output int sp0);
    rx0 = rx_cnt[idx];
    st0 = starts[idx];
    sp0 = stops[idx];
  endtask

  // Presents a request for one cycle (or leaves it held) and returns at the
  // first negedge after the accepting posedge.
  task automatic start_write(input int idx, input logic [15:0] r, input logic [7:0] d,
                             input bit hold);
    @(negedge clk);
    if (idx == 0) begin
      en_a = 1'b1; reg_a = r; data_a = d;
    end else begin
      en_b = 1'b1; reg_b = r[7:0]; data_b = d;
    end
    @(negedge clk);
    if (!hold) begin
      en_a = 1'b0;
      en_b = 1'b0;
    end
  endtask

  // Counts busy cycles; optionally pulses send_en for one cycle mid-frame.
  task automatic wait_idle(input int idx, input int glitch_at, output int cyc);
    cyc = 0;
    while (busy_of(idx) && cyc < 3000) begin
      if (glitch_at >= 0 && idx == 0) begin
        en_a = (cyc == glitch_at);
        if (cyc == glitch_at) begin
          reg_a  = 16'hFFFF;
          data_a = 8'hEE;
        end
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic check_frame(input string tag, input int idx, input int rx0, input int st0,
                             input int sp0, input int n, input logic [31:0] exp_bytes);
    chk({tag, "_nbytes"}, 32'(rx_cnt[idx] - rx0), 32'(n));
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_byte%0d", tag, k), 32'(rx_byte[idx][rx0 + k]),
          32'(exp_bytes[8*(n-1-k) +: 8]));
    end
    chk({tag, "_starts"}, 32'(starts[idx] - st0), 32'd1);
    chk({tag, "_stops"}, 32'(stops[idx] - sp0), 32'd1);
  endtask

  initial begin
    int cyc, rx0, st0, sp0;
    nack_at[0] = NONE;
    nack_at[1] = NONE;

    // Reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_scl_a", 32'(scl_a), 32'd1);
    chk("rst_sda_a", 32'(sda_a), 32'd1);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_nack_a", 32'(nack_a), 32'd0);
    chk("rst_scl_b", 32'(scl_b), 32'd1);
    chk("rst_sda_b", 32'(sda_b), 32'd1);
    chk("rst_busy_b", 32'(busy_b), 32'd0);
    chk("rst_nack_b", 32'(nack_b), 32'd0);

    // 16-bit register write
    snap(0, rx0, st0, sp0);
    start_write(0, 16'h3008, 8'h82, 1'b0);
    chk("ex1_busy_rise", 32'(busy_a), 32'd1);
    wait_idle(0, NONE, cyc);
    chk("ex1_busy_cycles", 32'(cyc), 32'd612);
    check_frame("ex1", 0, rx0, st0, sp0, 4, 32'h78300882);
    chk("ex1_nack", 32'(nack_a), 32'd0);

    // 8-bit register write
    snap(1, rx0, st0, sp0);
    start_write(1, 16'h003A, 8'h55, 1'b0);
    wait_idle(1, NONE, cyc);
    chk("ex0_busy_cycles", 32'(cyc), 32'd468);
    check_frame("ex0", 1, rx0, st0, sp0, 3, 32'h00783A55);

    // Slave NACKs the register low byte
    nack_at[0] = 2;
    snap(0, rx0, st0, sp0);
    start_write(0, 16'h1234, 8'hA5, 1'b0);
    wait_idle(0, NONE, cyc);
    chk("nak_busy_cycles", 32'(cyc), ACK_CHK ? 32'd468 : 32'd612);
    check_frame("nak", 0, rx0, st0, sp0, ACK_CHK ? 3 : 4,
                ACK_CHK ? 32'h00781234 : 32'h781234A5);
    chk("nak_flag", 32'(nack_a), 32'(ACK_CHK));
    repeat (10) @(negedge clk);
    chk("nak_hold", 32'(nack_a), 32'(ACK_CHK));
    nack_at[0] = NONE;

    // Next accept clears nack; a mid-frame send_en pulse is ignored
    snap(0, rx0, st0, sp0);
    start_write(0, 16'h5678, 8'h9A, 1'b0);
    chk("glt_nack_clr", 32'(nack_a), 32'd0);
    wait_idle(0, 100, cyc);
    chk("glt_busy_cycles", 32'(cyc), 32'd612);
    check_frame("glt", 0, rx0, st0, sp0, 4, 32'h7856789A);
    repeat (20) @(negedge clk);
    chk("glt_no_second", 32'(busy_a), 32'd0);

    // send_en held through the end of busy restarts immediately
    snap(0, rx0, st0, sp0);
    start_write(0, 16'hABCD, 8'hEF, 1'b1);
    wait_idle(0, NONE, cyc);
    chk("hold_busy1_cycles", 32'(cyc), 32'd612);
    chk("hold_gap", 32'(busy_a), 32'd0);
    @(negedge clk);
    chk("hold_restart", 32'(busy_a), 32'd1);
    en_a = 1'b0;
    wait_idle(0, NONE, cyc);
    chk("hold_busy2_cycles", 32'(cyc), 32'd612);
    chk("hold_nbytes", 32'(rx_cnt[0] - rx0), 32'd8);
    chk("hold_starts", 32'(starts[0] - st0), 32'd2);
    chk("hold_stops", 32'(stops[0] - sp0), 32'd2);
    chk("hold_f2_byte1", 32'(rx_byte[0][rx0 + 5]), 32'h0000_00AB);
    chk("hold_f2_byte3", 32'(rx_byte[0][rx0 + 7]), 32'h0000_00EF);

    // Reset during the second byte, then a normal write
    snap(0, rx0, st0, sp0);
    start_write(0, 16'h1111, 8'h22, 1'b0);
    repeat (200) @(negedge clk);
    chk("mrst_in_byte2", 32'(rx_cnt[0] - rx0), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_scl", 32'(scl_a), 32'd1);
    chk("mrst_sda", 32'(sda_a), 32'd1);
    chk("mrst_busy", 32'(busy_a), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    snap(0, rx0, st0, sp0);
    start_write(0, 16'h4300, 8'h30, 1'b0);
    wait_idle(0, NONE, cyc);
    chk("post_busy_cycles", 32'(cyc), 32'd612);
    check_frame("post", 0, rx0, st0, sp0, 4, 32'h78430030);
    chk("post_nack", 32'(nack_a), 32'd0);

    // Reset and send_en in the same cycle: request dropped
    @(negedge clk);
    rst_n = 1'b0;
    en_a  = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    en_a  = 1'b0;
    @(negedge clk);
    chk("rst_en_busy", 32'(busy_a), 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_en_scl", 32'(scl_a), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
